// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle unsigned add/subtract, CHUNK bits per clock from LSB to MSB.
// Optional: define ADDSUB_OVF_EN to add the signed-overflow output ovf.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH:0]   result
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic             sub_lat;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_work;

    logic [CHUNK-1:0] slice_a;
    logic [CHUNK-1:0] slice_b;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] sum_next;

    always_comb begin
        slice_a   = op_a[idx*CHUNK +: CHUNK];
        slice_b   = op_b[idx*CHUNK +: CHUNK];
        chunk_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{CHUNK{1'b0}}, carry};
        sum_next  = sum_work;
        sum_next[idx*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

`ifdef ADDSUB_OVF_EN
    // Carry into the operand MSB, only meaningful while the last chunk is processed.
    logic msb_cin;
    generate
        if (CHUNK == 1) begin : g_cin_bit
            assign msb_cin = carry;
        end else begin : g_cin_low
            logic [CHUNK-1:0] low_sum;
            assign low_sum = {1'b0, slice_a[CHUNK-2:0]} + {1'b0, slice_b[CHUNK-2:0]}
                           + {{(CHUNK-1){1'b0}}, carry};
            assign msb_cin = low_sum[CHUNK-1];
        end
    endgenerate
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            sub_lat  <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            sum_work <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
`ifdef ADDSUB_OVF_EN
            ovf      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                        op_a    <= a;
                        op_b    <= sub ? ~b : b;
                        carry   <= sub;
                        sub_lat <= sub;
                        idx     <= '0;
                        state   <= RUN;
                        busy    <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum_work <= sum_next;
                    carry    <= chunk_sum[CHUNK];
                    idx      <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        idx    <= '0;
                        state  <= FIN;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= {chunk_sum[CHUNK] ^ sub_lat, sum_next};
`ifdef ADDSUB_OVF_EN
                        ovf    <= msb_cin ^ chunk_sum[CHUNK];
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: CHUNK=4 main instance plus CHUNK=1 and CHUNK=16 variants.
`timescale 1ns/1ps
module tb_addsub_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start1, start16, sub;
    logic [15:0] a, b;
    logic        busy4, done4, busy1, done1, busy16, done16;
    logic [16:0] result4, result1, result16;
`ifdef ADDSUB_OVF_EN
    logic        ovf4, ovf1, ovf16;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(16), .CHUNK(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b),
        .busy(busy4), .done(done4),
`ifdef ADDSUB_OVF_EN
        .ovf(ovf4),
`endif
        .result(result4));

    addsub_seq #(.WIDTH(16), .CHUNK(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b),
        .busy(busy1), .done(done1),
`ifdef ADDSUB_OVF_EN
        .ovf(ovf1),
`endif
        .result(result1));

    addsub_seq #(.WIDTH(16), .CHUNK(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .sub(sub), .a(a), .b(b),
        .busy(busy16), .done(done16),
`ifdef ADDSUB_OVF_EN
        .ovf(ovf16),
`endif
        .result(result16));

    // One operation on the CHUNK=4 instance; operands are scrambled right after capture.
    task automatic run4(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                        input logic [16:0] exp, input logic eovf, input string name);
        int cyc;
        int bcnt;
        @(posedge clk); #1;
        a = va; b = vb; sub = vs; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; a = 16'h5A5A; b = 16'hA5A5; sub = ~vs;
        cyc = 0; bcnt = 0;
        while (!done4 && cyc < 50) begin
            if (busy4) bcnt++;
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (cyc != 4) begin n_fail++; $display("FAIL %s_latency: got %0d cycles, expected 4", name, cyc); end
        n_checks++;
        if (bcnt != 4) begin n_fail++; $display("FAIL %s_busy: busy for %0d cycles, expected 4", name, bcnt); end
        n_checks++;
        if (result4 !== exp) begin n_fail++; $display("FAIL %s_result: got %h, expected %h", name, result4, exp); end
`ifdef ADDSUB_OVF_EN
        n_checks++;
        if (ovf4 !== eovf) begin n_fail++; $display("FAIL %s_ovf: got %b, expected %b", name, ovf4, eovf); end
`else
        if (eovf === 1'bz) $display("unreachable");
`endif
        @(posedge clk); #1;
        n_checks++;
        if (done4 !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse: done still %b one cycle later", name, done4); end
        $display("op %s: a=%h b=%h sub=%b result=%h (expected %h)", name, va, vb, vs, result4, exp);
    endtask

    task automatic test_reset;
        n_checks++;
        if ({busy4, done4, busy1, done1, busy16, done16} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b, expected 000000", {busy4, done4, busy1, done1, busy16, done16});
        end
        n_checks++;
        if (result4 !== 17'h0 || result1 !== 17'h0 || result16 !== 17'h0) begin
            n_fail++; $display("FAIL reset_result: got %h/%h/%h, expected 0", result4, result1, result16);
        end
`ifdef ADDSUB_OVF_EN
        n_checks++;
        if (ovf4 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, expected 0", ovf4); end
`endif
        $display("reset: busy=%b done=%b result=%h", busy4, done4, result4);
    endtask

    task automatic test_add_sub;
        run4(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0, "add_carry");
        run4(16'h1234, 16'h1235, 1'b1, 17'h1FFFF, 1'b0, "sub_borrow");
        run4(16'h1235, 16'h1234, 1'b1, 17'h00001, 1'b0, "sub_plain");
    endtask

    task automatic test_start_while_busy;
        int dcnt;
        int done_cyc;
        logic [16:0] res_at_done;
        bit stable;
        @(posedge clk); #1;
        a = 16'h00FF; b = 16'h0001; sub = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        dcnt = 0; done_cyc = -1; stable = 1'b1; res_at_done = '0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc == 1) begin a = 16'hAAAA; b = 16'h1357; sub = 1'b1; start4 = 1'b1; end
            if (cyc == 2) start4 = 1'b0;
            if (done4) begin
                dcnt++;
                if (done_cyc < 0) begin done_cyc = cyc; res_at_done = result4; end
            end else if (dcnt == 0 && result4 !== 17'h00001) begin
                stable = 1'b0;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (dcnt != 1) begin n_fail++; $display("FAIL busy_start_dones: got %0d done pulses, expected 1", dcnt); end
        n_checks++;
        if (done_cyc != 4) begin n_fail++; $display("FAIL busy_start_latency: done at %0d, expected 4", done_cyc); end
        n_checks++;
        if (res_at_done !== 17'h00100) begin n_fail++; $display("FAIL busy_start_result: got %h, expected 00100", res_at_done); end
        n_checks++;
        if (!stable) begin n_fail++; $display("FAIL busy_start_hold: result changed before completion, expected 00001"); end
        $display("op start_while_busy: dones=%0d result=%h (expected 00100)", dcnt, res_at_done);
    endtask

    task automatic test_reset_mid_run;
        int dcnt;
        @(posedge clk); #1;
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy4 !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, expected 1", busy4); end
        rst = 1'b1; #1;
        n_checks++;
        if ({busy4, done4} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags: got %b, expected 00", {busy4, done4}); end
        n_checks++;
        if (result4 !== 17'h0) begin n_fail++; $display("FAIL midrst_result: got %h, expected 0", result4); end
        @(posedge clk); #1;
        rst = 1'b0;
        dcnt = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (done4) dcnt++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (dcnt != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d done pulses, expected 0", dcnt); end
        $display("op reset_mid_run: result=%h dones=%0d", result4, dcnt);
        run4(16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1, "after_reset");
    endtask

    task automatic test_back_to_back;
        int cyc;
        int gap;
        @(posedge clk); #1;
        a = 16'h0001; b = 16'h0002; sub = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 50) begin @(posedge clk); #1; cyc++; end
        n_checks++;
        if (cyc != 4 || result4 !== 17'h00003) begin
            n_fail++; $display("FAIL b2b_first: got %h after %0d cycles, expected 00003 after 4", result4, cyc);
        end
        a = 16'h0003; b = 16'h0005; sub = 1'b1; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        n_checks++;
        if (busy4 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b, expected 1 after start in done cycle", busy4); end
        gap = 1;
        while (!done4 && gap < 50) begin @(posedge clk); #1; gap++; end
        n_checks++;
        if (gap != 5) begin n_fail++; $display("FAIL b2b_gap: second done %0d cycles after first, expected 5", gap); end
        n_checks++;
        if (result4 !== 17'h1FFFE) begin n_fail++; $display("FAIL b2b_result: got %h, expected 1fffe", result4); end
        $display("op back_to_back: gap=%0d result=%h (expected 1fffe)", gap, result4);
    endtask

    task automatic test_chunk_variants;
        int t1, t16, b1cnt, b16cnt;
        logic [16:0] r1, r16;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; start1 = 1'b1; start16 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start16 = 1'b0; a = 16'h0000; b = 16'h0000;
        t1 = -1; t16 = -1; b1cnt = 0; b16cnt = 0; r1 = '0; r16 = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (busy1) b1cnt++;
            if (busy16) b16cnt++;
            if (done1 && t1 < 0) begin t1 = cyc; r1 = result1; end
            if (done16 && t16 < 0) begin t16 = cyc; r16 = result16; end
            @(posedge clk); #1;
        end
        n_checks++;
        if (t1 != 16 || b1cnt != 16) begin n_fail++; $display("FAIL chunk1_latency: done at %0d busy %0d, expected 16/16", t1, b1cnt); end
        n_checks++;
        if (r1 !== 17'h1FFFE) begin n_fail++; $display("FAIL chunk1_result: got %h, expected 1fffe", r1); end
        n_checks++;
        if (t16 != 1 || b16cnt != 1) begin n_fail++; $display("FAIL chunk16_latency: done at %0d busy %0d, expected 1/1", t16, b16cnt); end
        n_checks++;
        if (r16 !== 17'h1FFFE) begin n_fail++; $display("FAIL chunk16_result: got %h, expected 1fffe", r16); end
        $display("op chunk_variants: chunk1=%h@%0d chunk16=%h@%0d", r1, t1, r16, t16);
    endtask

`ifdef ADDSUB_OVF_EN
    task automatic test_ovf;
        run4(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1, "ovf_add");
        run4(16'h8000, 16'h0001, 1'b1, 17'h07FFF, 1'b1, "ovf_sub");
        run4(16'h0005, 16'h0003, 1'b1, 17'h00002, 1'b0, "ovf_none");
    endtask
`endif

    initial begin
        rst = 1'b1; start4 = 1'b0; start1 = 1'b0; start16 = 1'b0;
        sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_add_sub();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_chunk_variants();
`ifdef ADDSUB_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
